// File: rtl/vx_warp_ctl_pkg.sv
// Shared types for the warp-control responder: GPU control request structs,
// divergence-stack entry, and the core configuration the struct widths follow.
package vx_warp_ctl_pkg;

  localparam int NUM_WARPS               = 4;
  localparam int NUM_THREADS             = 4;
  localparam int NUM_BARRIERS            = 4;
  localparam int NW_BITS                 = $clog2(NUM_WARPS);
  localparam int NB_BITS                 = $clog2(NUM_BARRIERS);
  localparam int IPDOM_DEPTH_DEF         = 4;
  localparam logic [31:0] STARTUP_ADDR_DEF = 32'h8000_0000;

  typedef struct packed {
    logic                   valid;
    logic [NUM_THREADS-1:0] tmask;
  } gpu_tmc_t;

  typedef struct packed {
    logic                 valid;
    logic [NUM_WARPS-1:0] wmask;
    logic [31:0]          pc;
  } gpu_wspawn_t;

  typedef struct packed {
    logic                   valid;
    logic                   diverged;
    logic [NUM_THREADS-1:0] then_tmask;
    logic [NUM_THREADS-1:0] else_tmask;
    logic [31:0]            pc;
  } gpu_split_t;

  typedef struct packed {
    logic               valid;
    logic [NB_BITS-1:0] id;
    logic [NW_BITS-1:0] size_m1;
  } gpu_barrier_t;

  typedef struct packed {
    logic valid;
  } gpu_join_t;

  typedef struct packed {
    logic [NUM_THREADS-1:0] tmask;
    logic [31:0]            pc;
    logic                   is_else;
  } ipdom_entry_t;

  localparam int GPU_TMC_BITS     = $bits(gpu_tmc_t);
  localparam int GPU_WSPAWN_BITS  = $bits(gpu_wspawn_t);
  localparam int GPU_SPLIT_BITS   = $bits(gpu_split_t);
  localparam int GPU_BARRIER_BITS = $bits(gpu_barrier_t);
  localparam int GPU_JOIN_BITS    = $bits(gpu_join_t);
  localparam int IPDOM_ENTRY_BITS = $bits(ipdom_entry_t);

endpackage

// File: rtl/vx_warp_ctl_ipdom.sv
// Per-warp divergence stack (LIFO). A split pushes either the restore entry
// alone or the restore entry followed by the else entry, leaving else on top.
module vx_warp_ctl_ipdom
  import vx_warp_ctl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push1,
  input  logic         push2,
  input  logic         pop,
  input  ipdom_entry_t d_restore,
  input  ipdom_entry_t d_else,
  output ipdom_entry_t top_entry,
  output logic         empty,
  output logic         full1,
  output logic         full2
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  ipdom_entry_t  mem [DEPTH];
  logic [CW-1:0] cnt;
  logic [AW-1:0] wr_idx0;
  logic [AW-1:0] wr_idx1;
  logic [AW-1:0] top_idx;

  assign empty   = (cnt == '0);
  assign full1   = (cnt == CW'(DEPTH));
  assign full2   = (cnt >= CW'(DEPTH - 1));
  assign wr_idx0 = AW'(cnt);
  assign wr_idx1 = AW'(cnt + CW'(1));
  assign top_idx = AW'(cnt - CW'(1));
  assign top_entry = mem[top_idx];

  // Contents need no reset: only entries below cnt are ever read.
  always_ff @(posedge clk) begin
    if (push2 && !full2) begin
      mem[wr_idx0] <= d_restore;
      mem[wr_idx1] <= d_else;
    end else if (push1 && !full1) begin
      mem[wr_idx0] <= d_restore;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (push2 && !full2) begin
      cnt <= cnt + CW'(2);
    end else if (push1 && !full1) begin
      cnt <= cnt + CW'(1);
    end else if (pop && !empty) begin
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/vx_warp_ctl.sv
// Warp-control responder: applies TMC/WSPAWN/SPLIT/BARRIER/JOIN requests to the
// per-warp scheduling state and drives registered masks and PC redirects.
module vx_warp_ctl
  import vx_warp_ctl_pkg::*;
#(
  parameter int          IPDOM_DEPTH  = IPDOM_DEPTH_DEF,
  parameter logic [31:0] STARTUP_ADDR = STARTUP_ADDR_DEF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             ctl_valid,
  output logic                             ctl_ready,
  input  logic [NW_BITS-1:0]               ctl_wid,
  input  gpu_tmc_t                         tmc,
  input  gpu_wspawn_t                      wspawn,
  input  gpu_split_t                       split,
  input  gpu_barrier_t                     barrier,
  input  logic                             join_valid,
  output logic [NUM_WARPS-1:0]             active_warps,
  output logic [NUM_WARPS-1:0]             stalled_warps,
  output logic [NUM_WARPS*NUM_THREADS-1:0] thread_masks,
  output logic                             redirect_valid,
  output logic [NW_BITS-1:0]               redirect_wid,
  output logic [31:0]                      redirect_pc,
  output logic                             spawn_valid,
  output logic [NUM_WARPS-1:0]             spawn_mask,
  output logic [31:0]                      spawn_pc,
  output logic                             ipdom_error
);

  logic [NUM_THREADS-1:0] tmask_r  [NUM_WARPS];
  logic [NW_BITS-1:0]     bar_cnt  [NUM_BARRIERS];
  logic [NUM_WARPS-1:0]   bar_mask [NUM_BARRIERS];

  logic sel_tmc, sel_wspawn, sel_split, sel_bar, sel_join;
  logic room, fire;

  ipdom_entry_t         stk_top [NUM_WARPS];
  ipdom_entry_t         ent_restore, ent_else;
  logic [NUM_WARPS-1:0] stk_empty, stk_full1, stk_full2;
  logic [NUM_WARPS-1:0] push1, push2, pop;

  always_comb begin
    sel_tmc     = tmc.valid;
    sel_wspawn  = !tmc.valid && wspawn.valid;
    sel_split   = !tmc.valid && !wspawn.valid && split.valid;
    sel_bar     = !tmc.valid && !wspawn.valid && !split.valid && barrier.valid;
    sel_join    = !tmc.valid && !wspawn.valid && !split.valid && !barrier.valid && join_valid;
    room        = split.diverged ? !stk_full2[ctl_wid] : !stk_full1[ctl_wid];
    ctl_ready   = !(sel_split && !room);
    fire        = ctl_valid && ctl_ready;
    push1       = '0;
    push2       = '0;
    pop         = '0;
    if (fire && sel_split) begin
      if (split.diverged) push2[ctl_wid] = 1'b1;
      else                push1[ctl_wid] = 1'b1;
    end
    if (fire && sel_join && !stk_empty[ctl_wid]) pop[ctl_wid] = 1'b1;
    ent_restore = '{tmask: tmask_r[ctl_wid], pc: 32'h0, is_else: 1'b0};
    ent_else    = '{tmask: split.else_tmask, pc: split.pc, is_else: 1'b1};
  end

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    vx_warp_ctl_ipdom #(.DEPTH(IPDOM_DEPTH)) u_ipdom (
      .clk       (clk),
      .reset     (reset),
      .push1     (push1[w]),
      .push2     (push2[w]),
      .pop       (pop[w]),
      .d_restore (ent_restore),
      .d_else    (ent_else),
      .top_entry (stk_top[w]),
      .empty     (stk_empty[w]),
      .full1     (stk_full1[w]),
      .full2     (stk_full2[w])
    );
    assign thread_masks[w*NUM_THREADS +: NUM_THREADS] = tmask_r[w];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_warps   <= NUM_WARPS'(1);
      stalled_warps  <= '0;
      for (int w = 0; w < NUM_WARPS; w++) tmask_r[w] <= (w == 0) ? NUM_THREADS'(1) : '0;
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        bar_cnt[b]  <= '0;
        bar_mask[b] <= '0;
      end
      redirect_valid <= 1'b0;
      redirect_wid   <= '0;
      redirect_pc    <= STARTUP_ADDR;
      spawn_valid    <= 1'b0;
      spawn_mask     <= '0;
      spawn_pc       <= '0;
      ipdom_error    <= 1'b0;
    end else begin
      redirect_valid <= 1'b0;
      spawn_valid    <= 1'b0;
      // Cannot happen through the handshake; kept as a guard on the stacks.
      if (|(push1 & stk_full1) || |(push2 & stk_full2)) ipdom_error <= 1'b1;
      if (fire) begin
        if (sel_tmc) begin
          tmask_r[ctl_wid] <= tmc.tmask;
          if (tmc.tmask == '0) active_warps[ctl_wid] <= 1'b0;
        end else if (sel_wspawn) begin
          for (int w = 0; w < NUM_WARPS; w++) begin
            if (wspawn.wmask[w] && (NW_BITS'(w) != ctl_wid)) begin
              active_warps[w] <= 1'b1;
              tmask_r[w]      <= NUM_THREADS'(1);
            end
          end
          spawn_valid <= 1'b1;
          spawn_mask  <= wspawn.wmask & ~(NUM_WARPS'(1) << ctl_wid);
          spawn_pc    <= wspawn.pc;
        end else if (sel_split) begin
          if (split.diverged) tmask_r[ctl_wid] <= split.then_tmask;
        end else if (sel_bar) begin
          if (bar_cnt[barrier.id] < barrier.size_m1) begin
            bar_cnt[barrier.id]           <= bar_cnt[barrier.id] + NW_BITS'(1);
            bar_mask[barrier.id][ctl_wid] <= 1'b1;
            stalled_warps[ctl_wid]        <= 1'b1;
          end else begin
            stalled_warps       <= stalled_warps & ~bar_mask[barrier.id];
            bar_cnt[barrier.id]  <= '0;
            bar_mask[barrier.id] <= '0;
          end
        end else if (sel_join) begin
          if (stk_empty[ctl_wid]) begin
            ipdom_error <= 1'b1;
          end else begin
            tmask_r[ctl_wid] <= stk_top[ctl_wid].tmask;
            if (stk_top[ctl_wid].is_else) begin
              redirect_valid <= 1'b1;
              redirect_wid   <= ctl_wid;
              redirect_pc    <= stk_top[ctl_wid].pc;
            end
          end
        end
      end
    end
  end

endmodule

// File: doc/vx_warp_ctl.md
# VX_warp_ctl

Warp-control responder in the core's issue/scheduling path. It consumes GPU control requests (TMC, WSPAWN, SPLIT, BARRIER, plus JOIN) issued by the GPU execute unit and applies them to per-warp scheduling state. That state is the active mask, stall mask, per-warp thread masks, divergence stacks and barrier counters. The block drives the results to the warp scheduler as registered state and PC redirects.

## Interface
- NUM_WARPS, `NUM_WARPS: warp count.
- NUM_THREADS, `NUM_THREADS: threads per warp.
- NUM_BARRIERS, `NUM_BARRIERS: barrier ids (NB_BITS = clog2).
- IPDOM_DEPTH, 4: divergence-stack entries per warp (≥2).
- STARTUP_ADDR, `STARTUP_ADDR: warp-0 reset PC.

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ctl_valid  in  1  request valid
- ctl_ready  out  1  request accepted when valid && ready
- ctl_wid  in  NW_BITS  issuing warp
- tmc  in  GPU_TMC_BITS  gpu_tmc_t
- wspawn  in  GPU_WSPAWN_BITS  gpu_wspawn_t
- split  in  GPU_SPLIT_BITS  gpu_split_t
- barrier  in  GPU_BARRIER_BITS  gpu_barrier_t
- join_valid  in  1  join request (sub-op of ctl_valid)
- active_warps  out  NUM_WARPS  warp active mask
- stalled_warps  out  NUM_WARPS  warps blocked at a barrier
- thread_masks  out  NUM_WARPS*NUM_THREADS  per-warp tmask, warp w at [w*NUM_THREADS +: NUM_THREADS]
- redirect_valid / redirect_wid / redirect_pc  out  1/NW_BITS/32  single-warp PC redirect pulse
- spawn_valid / spawn_mask / spawn_pc  out  1/NUM_WARPS/32  multi-warp start pulse
- ipdom_error  out  1  sticky: overflow or join on empty stack

## Operation
- Sub-op selected by struct valid bits. Priority when more than one is set: tmc > wspawn > split > barrier > join. Only the winner executes.
- TMC: thread_masks[wid] = tmask. If tmask == 0, clear active_warps[wid].
- WSPAWN: for each w in wmask with w != wid, set active, tmask = thread 0 only. Pulse spawn_valid with spawn_mask = wmask & ~(1<<wid) and spawn_pc = pc.
- SPLIT, diverged: push restore entry {tmask=current, is_else=0}, then else entry {tmask=else_tmask, pc, is_else=1}. Set tmask = then_tmask.
- SPLIT, not diverged: push restore entry only.
- JOIN: pop one entry and set tmask = entry.tmask. If is_else, also pulse a redirect to entry.pc for wid. On an empty stack: no state change, set ipdom_error.
- BARRIER: counter[id] compared to size_m1.
  - count < size_m1: count++, set stalled_warps[wid], record wid in bar_mask[id].
  - count == size_m1 (last arrival): clear stalled bits of bar_mask[id]; the arriving warp is never stalled; reset count and mask to 0.
- ctl_ready = 0 only when the winning sub-op is a split and the target stack lacks room. Room means 2 free slots if diverged, 1 if not. Otherwise ctl_ready = 1. An overflow therefore cannot occur through the handshake; ipdom_error on overflow is defensive.
- Reset values:
  - active_warps = 1, thread_masks = thread 0 of warp 0 only, stalled_warps = 0.
  - All stacks empty, all barrier counts and masks 0, ipdom_error = 0.
  - spawn_valid = 0, redirect_valid = 0. redirect_pc = STARTUP_ADDR.

## Timing
- Request accepted at edge N; all state and output updates are visible after edge N (1-cycle latency). redirect_valid and spawn_valid are single-cycle pulses.
- No internal pipelining: one request per cycle sustained.
- A barrier release and a new arrival at the same id cannot coincide, because there is one request per cycle. The first arrival after a release starts a new count.
- A TMC to zero on a warp stalled at a barrier clears active and leaves the stalled bit untouched.
- Reset mid-operation discards all stack and barrier contents in the same cycle.

## Structure
- Add `gpu_join_t` {valid} and `ipdom_entry_t` {tmask, pc, is_else} to the VX_gpu_types package. Add `IPDOM_ENTRY_BITS` alongside the existing bit-width macros.
- Sub-module VX_ipdom_stack: a per-warp LIFO instantiated NUM_WARPS times. It has push1/push2/pop, full-for-2/full-for-1/empty flags, and synchronous reset.
- Barrier counters and masks live in flops in the top level.

## Test plan
- Reset: active_warps = 0x1, warp-0 tmask = 0x1, stalled = 0, ipdom_error = 0.
- WSPAWN from warp 0, wmask = 0xF, pc = 0x8000_0100: the next cycle shows active = 0xF, warps 1–3 tmask = 0x1, and spawn_valid pulses with mask = 0xE.
- Split on warp 1, tmask 0xF, diverged, then = 0x3, else = 0xC, pc = 0x200:
  - The split sets tmask = 0x3.
  - Join 1 sets tmask = 0xC and redirects warp 1 to 0x200.
  - Join 2 sets tmask = 0xF with no redirect.
  - Join 3 sets ipdom_error with tmask unchanged.
- Barrier id 2, size_m1 = 2:
  - Warps 0 and 3 arrive and stalled = 0x9.
  - Warp 1 arrives, stalled = 0x0 the next cycle, and the count resets.
- IPDOM_DEPTH = 4: two diverged splits on warp 0 are accepted. A third split holds ctl_ready = 0 and leaves state unchanged until a join frees room.
- Simultaneous tmc.valid and barrier.valid: only TMC applies and the barrier count is unchanged. TMC tmask = 0 clears the warp's active bit.
